// File: rtl/rx_serial_aligner.sv
// rtl/rx_serial_aligner.sv - serial lane byte aligner: COM hunt, lock count, data byte extraction
// Fill symbols (COM/IDL) are dropped once active; every other byte strobes valid_out for one cycle.
module rx_serial_aligner #(
  parameter logic [7:0] COM        = 8'hBC,
  parameter logic [7:0] IDL        = 8'h7C,
  parameter int         SYNC_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
  output logic       byte_boundary
);

  typedef enum logic [1:0] {HUNT, LOCK, ACTIVE} state_t;

  localparam logic [3:0] SYNC_TARGET = 4'(SYNC_COUNT);

  state_t     state, state_nxt;
  logic [7:0] sr;
  logic [7:0] cand;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [3:0] com_cnt, com_cnt_nxt;
  logic [7:0] data_nxt;
  logic       valid_nxt;
  logic       boundary_nxt;
  logic       at_boundary;

  // cand is the byte completed by the bit sampled at this edge
  assign cand        = {sr[6:0], data_in};
  assign at_boundary = (bit_cnt == 3'd7);

  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt + 3'd1;
    com_cnt_nxt  = com_cnt;
    data_nxt     = data_out;
    valid_nxt    = 1'b0;
    boundary_nxt = 1'b0;
    case (state)
      HUNT: begin
        // bit_cnt stays at 0 so the first bit after a found COM is bit 0
        bit_cnt_nxt = 3'd0;
        if (cand == COM) begin
          com_cnt_nxt = 4'd1;
          state_nxt   = (SYNC_TARGET == 4'd1) ? ACTIVE : LOCK;
        end
      end
      LOCK: begin
        if (at_boundary) begin
          boundary_nxt = 1'b1;
          if (cand == COM) begin
            com_cnt_nxt = com_cnt + 4'd1;
            if (com_cnt + 4'd1 == SYNC_TARGET) state_nxt = ACTIVE;
          end else begin
            com_cnt_nxt = 4'd0;
            state_nxt   = HUNT;
          end
        end
      end
      ACTIVE: begin
        if (at_boundary) begin
          boundary_nxt = 1'b1;
          if (cand != COM && cand != IDL) begin
            data_nxt  = cand;
            valid_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt   = HUNT;
        bit_cnt_nxt = 3'd0;
        com_cnt_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state         <= HUNT;
      sr            <= 8'h00;
      bit_cnt       <= 3'd0;
      com_cnt       <= 4'd0;
      data_out      <= 8'h00;
      valid_out     <= 1'b0;
      active        <= 1'b0;
      byte_boundary <= 1'b0;
    end else begin
      state         <= state_nxt;
      sr            <= cand;
      bit_cnt       <= bit_cnt_nxt;
      com_cnt       <= com_cnt_nxt;
      data_out      <= data_nxt;
      valid_out     <= valid_nxt;
      active        <= (state_nxt == ACTIVE);
      byte_boundary <= boundary_nxt;
    end
  end

endmodule

// File: doc/rx_serial_aligner.md
Name: rx_serial_aligner

Overview:
Receive-side front end of the PHY that turns one serial lane back into bytes. It sits directly downstream of the transmit paralelo_serial stage. It takes the serial bitstream in the clk_32f domain, finds byte alignment by hunting for the COM symbol, and declares the lane active after SYNC_COUNT consecutive aligned COMs. Once active, it emits data bytes with a one-cycle valid strobe and suppresses COM and IDL fill symbols, feeding the downstream 8-to-32 packing stage.

Parameters:
COM, 8'hBC, comma/alignment symbol
IDL, 8'h7C, idle fill symbol (never forwarded)
SYNC_COUNT, 4, consecutive aligned COMs required to enter ACTIVE (range 1..15)

Ports:
clk_32f  input  1  serial bit clock; all state on rising edge
reset  input  1  synchronous, active-high
data_in  input  1  serial bit; MSB of each byte first
data_out  output  8  last forwarded data byte
valid_out  output  1  one-cycle strobe: data_out updated this cycle
active  output  1  high while lane is aligned (state ACTIVE)
byte_boundary  output  1  one-cycle pulse at every evaluated byte boundary in LOCK/ACTIVE

Behaviour:
- Clocking: one edge, one bit. The shift register sr[7:0] updates as sr <= {sr[6:0], data_in} on every edge, except during reset.
- Candidate byte at an edge: cand = {sr[6:0], data_in}, i.e. the byte completed by the bit sampled at that edge.
- Reset (reset=1 at an edge): sr=0, bit_cnt=0, com_cnt=0, state=HUNT, data_out=8'h00, valid_out=0, active=0, byte_boundary=0. Reset takes priority over every other event, mid-byte or mid-ACTIVE.
- HUNT: cand is checked on every edge (bit-granular search).
  - cand==COM: go to LOCK, bit_cnt=0, com_cnt=1.
  - If SYNC_COUNT==1, go straight to ACTIVE instead.
- LOCK: bit_cnt increments 0..7 and wraps. At bit_cnt==7 (boundary edge), byte_boundary=1 for that cycle.
  - cand==COM: com_cnt++. If com_cnt+1==SYNC_COUNT, go to ACTIVE.
  - cand!=COM: go to HUNT, com_cnt=0. The search restarts on the next edge; the failing byte is not re-examined.
- ACTIVE: bit_cnt keeps counting. At each boundary edge, byte_boundary=1 and:
  - cand==COM or cand==IDL: valid_out=0, data_out holds.
  - otherwise: data_out=cand, valid_out=1 for exactly one cycle.
  - ACTIVE is left only by reset. COMs in ACTIVE do not re-align.
- Outputs are registered. The byte whose last bit is sampled at edge k appears on data_out/valid_out after edge k, i.e. latency is one edge from its last bit.
- Outside boundary edges, valid_out=0.
- Maximum throughput is one valid_out per 8 clocks.
- active = (state==ACTIVE), registered. It rises at the boundary edge of the SYNC_COUNT-th COM.
- com_cnt is 4 bits wide and saturates at no value other than SYNC_COUNT.
- Any bit offset 0..7 of the first COM relative to reset release must lock identically.

Test Plan:
1. Reset then idle zeros -> active=0, valid_out=0, data_out=00 for 100 cycles, byte_boundary never pulses.
2. Three junk bits (101), then BC BC BC BC, then A5 -> active rises at the edge sampling the last bit of the 4th BC; valid_out pulses exactly 8 edges later with data_out=A5.
3. Aligned lane sends 7C, BC, 3C, 7C -> single valid_out pulse with data_out=3C; data_out still 3C afterwards.
4. BC BC 55 BC BC BC BC 11 -> HUNT re-entered after 55, active asserted only after the later four BCs, then data_out=11 valid.
5. Repeat scenario 2 for every bit offset 0..7 -> identical output timing relative to the 4th BC.
6. reset=1 for one cycle in mid-byte while ACTIVE -> all outputs 0 next cycle; relock requires four fresh BCs.
